// File: rtl/thermo_pkg.sv
// Shared types and constants for the temperature sample controller.
//   state_e    : sampling FSM states
//   SEG_*      : active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   bcd_to_seg : decimal digit 0-9 to segment pattern; other codes give a blank
package thermo_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/thermo_seg_mux.sv
// Two-digit multiplexed 7-segment driver.
//   clk, rst   : clock, asynchronous active-high reset
//   enable     : low blanks the display (an=11, seg=7F)
//   temp_out   : value to show, saturated at 99
//   sensor_err : shows "-" on both digits
//   seg        : shared active-low segments {g,f,e,d,c,b,a} (registered)
//   an         : active-low anodes, an[0] units, an[1] tens (registered)
// The scan counter is free-running and ignores enable.
module thermo_seg_mux
  import thermo_pkg::*;
#(
  parameter int unsigned SCAN_PERIOD = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] temp_out,
  input  logic       sensor_err,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int unsigned SW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

  logic [SW-1:0] scan_q;
  logic          digit_q;  // 0 = units lit, 1 = tens lit

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q  <= '0;
      digit_q <= 1'b0;
    end else if (scan_q == SW'(SCAN_PERIOD - 1)) begin
      scan_q  <= '0;
      digit_q <= ~digit_q;
    end else begin
      scan_q <= scan_q + 1'b1;
    end
  end

  logic [6:0] val;
  logic [3:0] tens, units;
  logic [6:0] seg_d;
  logic [1:0] an_d;

  always_comb begin
    val   = (temp_out > 8'd99) ? 7'd99 : temp_out[6:0];
    tens  = 4'(val / 7'd10);
    units = 4'(val % 7'd10);
    seg_d = SEG_BLANK;
    an_d  = 2'b11;
    if (enable) begin
      an_d = digit_q ? 2'b01 : 2'b10;
      if (sensor_err) begin
        seg_d = SEG_DASH;
      end else if (digit_q) begin
        seg_d = (tens == 4'd0) ? SEG_BLANK : bcd_to_seg(tens);
      end else begin
        seg_d = bcd_to_seg(units);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_BLANK;
      an  <= 2'b11;
    end else begin
      seg <= seg_d;
      an  <= an_d;
    end
  end

endmodule

// File: rtl/thermo_sample_ctrl.sv
// Periodic temperature sampler with req/ack sensor handshake and 2-digit display.
//   clk, rst   : clock, asynchronous active-high reset
//   enable     : run sampling and display; low idles the FSM and blanks the display
//   conv_req   : conversion request to the sensor
//   conv_ack   : single-cycle acknowledge, conv_data valid with it
//   conv_data  : unsigned temperature in degrees C
//   temp_out   : latest captured (or averaged) temperature
//   temp_valid : one-cycle pulse when temp_out updates
//   sensor_err : set on request timeout, cleared by the next ack
//   seg, an    : multiplexed active-low segment bus and anodes
// Define THERMO_AVG_EN to report the mean of the last 4 captured samples.
module thermo_sample_ctrl
  import thermo_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = 1000000,
  parameter int unsigned TIMEOUT       = 1024,
  parameter int unsigned SCAN_PERIOD   = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       conv_req,
  input  logic       conv_ack,
  input  logic [7:0] conv_data,
  output logic [7:0] temp_out,
  output logic       temp_valid,
  output logic       sensor_err,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int unsigned SPW = $clog2(SAMPLE_PERIOD);
  localparam int unsigned TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e         state;
  logic [SPW-1:0] sample_cnt;
  logic [TW-1:0]  tmo_cnt;
  logic [7:0]     new_temp;

  logic accept;
  assign accept = enable && (state == REQ) && conv_ack;

`ifdef THERMO_AVG_EN
  // Three stored samples; the incoming one completes the window of four.
  logic [7:0] hist_q [3];
  logic       primed_q;
  logic [9:0] sum;

  always_comb begin
    sum = 10'(conv_data) + 10'(hist_q[0]) + 10'(hist_q[1]) + 10'(hist_q[2]);
    new_temp = primed_q ? 8'(sum >> 2) : conv_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q[0] <= '0;
      hist_q[1] <= '0;
      hist_q[2] <= '0;
      primed_q  <= 1'b0;
    end else if (!enable) begin
      primed_q <= 1'b0;
    end else if (accept) begin
      primed_q <= 1'b1;
      if (primed_q) begin
        hist_q[0] <= conv_data;
        hist_q[1] <= hist_q[0];
        hist_q[2] <= hist_q[1];
      end else begin
        hist_q[0] <= conv_data;
        hist_q[1] <= conv_data;
        hist_q[2] <= conv_data;
      end
    end
  end
`else
  assign new_temp = conv_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      conv_req   <= 1'b0;
      sample_cnt <= '0;
      tmo_cnt    <= '0;
      temp_out   <= '0;
      temp_valid <= 1'b0;
      sensor_err <= 1'b0;
    end else begin
      temp_valid <= 1'b0;
      if (!enable) begin
        state      <= IDLE;
        conv_req   <= 1'b0;
        sample_cnt <= '0;
        tmo_cnt    <= '0;
      end else begin
        case (state)
          IDLE: begin
            state    <= REQ;
            conv_req <= 1'b1;
            tmo_cnt  <= '0;
          end
          REQ: begin
            // Ack takes priority over a timeout expiring in the same cycle.
            if (conv_ack) begin
              temp_out   <= new_temp;
              temp_valid <= 1'b1;
              sensor_err <= 1'b0;
              conv_req   <= 1'b0;
              sample_cnt <= '0;
              state      <= WAIT;
            end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
              sensor_err <= 1'b1;
              conv_req   <= 1'b0;
              sample_cnt <= '0;
              state      <= WAIT;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          WAIT: begin
            if (sample_cnt == SPW'(SAMPLE_PERIOD - 1)) begin
              state    <= REQ;
              conv_req <= 1'b1;
              tmo_cnt  <= '0;
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  thermo_seg_mux #(
    .SCAN_PERIOD (SCAN_PERIOD)
  ) u_seg_mux (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .temp_out   (temp_out),
    .sensor_err (sensor_err),
    .seg        (seg),
    .an         (an)
  );

endmodule

// File: tb/tb_thermo_sample_ctrl.sv
module tb_thermo_sample_ctrl;

  localparam int unsigned SP   = 16;
  localparam int unsigned TMO  = 8;
  localparam int unsigned SCAN = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       conv_req;
  logic       conv_ack;
  logic [7:0] conv_data;
  logic [7:0] temp_out;
  logic       temp_valid;
  logic       sensor_err;
  logic [6:0] seg;
  logic [1:0] an;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  thermo_sample_ctrl #(
    .SAMPLE_PERIOD (SP),
    .TIMEOUT       (TMO),
    .SCAN_PERIOD   (SCAN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .conv_req   (conv_req),
    .conv_ack   (conv_ack),
    .conv_data  (conv_data),
    .temp_out   (temp_out),
    .temp_valid (temp_valid),
    .sensor_err (sensor_err),
    .seg        (seg),
    .an         (an)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d required < 20000", cyc);
    $fatal(1, "watchdog");
  end

  // Waits (bounded) at falling edges for conv_req to be high.
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < int'(SP) + 10; i++) begin
      if (conv_req === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  // Collects one tens and one units segment value and whether the lit digit
  // held for exactly SCAN cycles before switching.
  task automatic observe_display(output logic [6:0] st, output logic [6:0] su,
                                 output bit period_ok);
    logic [1:0] prev, v;
    bit changed;
    st = 'x;
    su = 'x;
    period_ok = 1'b0;
    changed = 1'b0;
    @(negedge clk);
    prev = an;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (an !== prev) begin
        changed = 1'b1;
        break;
      end
    end
    if (!changed) return;
    v = an;
    if (v == 2'b01) st = seg; else su = seg;
    period_ok = (v == 2'b01) || (v == 2'b10);
    for (int k = 1; k < int'(SCAN); k++) begin
      @(negedge clk);
      if (an !== v) period_ok = 1'b0;
    end
    @(negedge clk);
    if (an !== ~v) period_ok = 1'b0;
    if (an == 2'b01) st = seg; else su = seg;
  endtask

  // Drop enable briefly so each scenario starts from IDLE (and a fresh average).
  task automatic restart();
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
  endtask

  // Acks in the first REQ cycle; leaves the bench at the cycle after the ack.
  task automatic ack_now(input logic [7:0] d, output bit ok);
    wait_req(ok);
    conv_ack  = 1'b1;
    conv_data = d;
    @(negedge clk);
    conv_ack  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    conv_ack = 1'b0;
    conv_data = 8'd0;
    repeat (2) @(negedge clk);
    checks++; if (conv_req !== 1'b0) begin errors++; $display("FAIL rst_conv_req got %b want 0", conv_req); end
    checks++; if (temp_out !== 8'd0) begin errors++; $display("FAIL rst_temp_out got %0d want 0", temp_out); end
    checks++; if (temp_valid !== 1'b0) begin errors++; $display("FAIL rst_temp_valid got %b want 0", temp_valid); end
    checks++; if (sensor_err !== 1'b0) begin errors++; $display("FAIL rst_sensor_err got %b want 0", sensor_err); end
    checks++; if (an !== 2'b11) begin errors++; $display("FAIL rst_an got %b want 11", an); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL rst_seg got %h want 7f", seg); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (an !== 2'b11) begin errors++; $display("FAIL idle_an got %b want 11", an); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL idle_seg got %h want 7f", seg); end
    checks++; if (conv_req !== 1'b0) begin errors++; $display("FAIL idle_conv_req got %b want 0", conv_req); end
  endtask

  task automatic test_sample();
    bit ok, pok;
    int ack_cyc;
    logic [6:0] st, su;
    enable = 1'b1;
    @(negedge clk);
    checks++; if (conv_req !== 1'b1) begin errors++; $display("FAIL first_req got %b want 1", conv_req); end
    @(negedge clk);
    conv_ack  = 1'b1;
    conv_data = 8'd37;
    ack_cyc   = cyc;
    @(negedge clk);
    conv_ack  = 1'b0;
    checks++; if (conv_req !== 1'b0) begin errors++; $display("FAIL req_drop got %b want 0", conv_req); end
    checks++; if (temp_valid !== 1'b1) begin errors++; $display("FAIL valid_pulse got %b want 1", temp_valid); end
    checks++; if (temp_out !== 8'd37) begin errors++; $display("FAIL temp_37 got %0d want 37", temp_out); end
    @(negedge clk);
    checks++; if (temp_valid !== 1'b0) begin errors++; $display("FAIL valid_one_cycle got %b want 0", temp_valid); end
    observe_display(st, su, pok);
    checks++; if (pok !== 1'b1) begin errors++; $display("FAIL scan_period_37 got %b want 1", pok); end
    checks++; if (st !== 7'h30) begin errors++; $display("FAIL seg_tens_37 got %h want 30", st); end
    checks++; if (su !== 7'h78) begin errors++; $display("FAIL seg_units_37 got %h want 78", su); end
    while (conv_req !== 1'b1 && cyc - ack_cyc < 40) @(negedge clk);
    checks++; if (cyc - ack_cyc !== int'(SP) + 1) begin
      errors++; $display("FAIL next_req_delay got %0d want %0d", cyc - ack_cyc, SP + 1);
    end
  endtask

  task automatic test_blank();
    bit ok, pok;
    logic [6:0] st, su;
    restart();
    ack_now(8'd5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL req_wait_5 got timeout want req"); end
    checks++; if (temp_out !== 8'd5) begin errors++; $display("FAIL temp_5 got %0d want 5", temp_out); end
    observe_display(st, su, pok);
    checks++; if (st !== 7'h7F) begin errors++; $display("FAIL seg_tens_5 got %h want 7f", st); end
    checks++; if (su !== 7'h12) begin errors++; $display("FAIL seg_units_5 got %h want 12", su); end
  endtask

  task automatic test_saturate();
    bit ok, pok;
    logic [6:0] st, su;
    restart();
    ack_now(8'd150, ok);
    checks++; if (!ok) begin errors++; $display("FAIL req_wait_150 got timeout want req"); end
    checks++; if (temp_out !== 8'd150) begin errors++; $display("FAIL temp_150 got %0d want 150", temp_out); end
    observe_display(st, su, pok);
    checks++; if (st !== 7'h10) begin errors++; $display("FAIL seg_tens_99 got %h want 10", st); end
    checks++; if (su !== 7'h10) begin errors++; $display("FAIL seg_units_99 got %h want 10", su); end
  endtask

  task automatic test_timeout();
    bit ok, pok;
    int n;
    logic [6:0] st, su;
    restart();
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("FAIL req_wait_tmo got timeout want req"); end
    n = 0;
    while (conv_req === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++; if (n !== int'(TMO)) begin errors++; $display("FAIL req_high_len got %0d want %0d", n, TMO); end
    checks++; if (sensor_err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", sensor_err); end
    checks++; if (temp_out !== 8'd150) begin errors++; $display("FAIL tmo_hold got %0d want 150", temp_out); end
    observe_display(st, su, pok);
    checks++; if (st !== 7'h3F) begin errors++; $display("FAIL dash_tens got %h want 3f", st); end
    checks++; if (su !== 7'h3F) begin errors++; $display("FAIL dash_units got %h want 3f", su); end
    ack_now(8'd20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL req_wait_20 got timeout want req"); end
    checks++; if (sensor_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", sensor_err); end
    observe_display(st, su, pok);
    checks++; if (st !== 7'h24) begin errors++; $display("FAIL seg_tens_20 got %h want 24", st); end
    checks++; if (su !== 7'h40) begin errors++; $display("FAIL seg_units_20 got %h want 40", su); end
  endtask

  task automatic test_coincident();
    bit ok;
    restart();
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("FAIL req_wait_coin got timeout want req"); end
    repeat (TMO - 1) @(negedge clk);
    conv_ack  = 1'b1;
    conv_data = 8'd63;
    @(negedge clk);
    conv_ack  = 1'b0;
    checks++; if (temp_out !== 8'd63) begin errors++; $display("FAIL coin_temp got %0d want 63", temp_out); end
    checks++; if (temp_valid !== 1'b1) begin errors++; $display("FAIL coin_valid got %b want 1", temp_valid); end
    checks++; if (sensor_err !== 1'b0) begin errors++; $display("FAIL coin_err got %b want 0", sensor_err); end
  endtask

  task automatic test_disable();
    bit ok;
    restart();
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("FAIL req_wait_dis got timeout want req"); end
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++; if (conv_req !== 1'b0) begin errors++; $display("FAIL dis_req got %b want 0", conv_req); end
    conv_ack  = 1'b1;
    conv_data = 8'd77;
    @(negedge clk);
    conv_ack  = 1'b0;
    checks++; if (temp_valid !== 1'b0) begin errors++; $display("FAIL dis_valid got %b want 0", temp_valid); end
    checks++; if (temp_out !== 8'd63) begin errors++; $display("FAIL dis_hold got %0d want 63", temp_out); end
    repeat (2) @(negedge clk);
    checks++; if (an !== 2'b11) begin errors++; $display("FAIL dis_an got %b want 11", an); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL dis_seg got %h want 7f", seg); end
    checks++; if (conv_req !== 1'b0) begin errors++; $display("FAIL dis_req_stay got %b want 0", conv_req); end
  endtask

`ifdef THERMO_AVG_EN
  task automatic test_average();
    bit ok;
    logic [7:0] ins [4];
    logic [7:0] exp [4];
    ins = '{8'd40, 8'd40, 8'd40, 8'd44};
    exp = '{8'd40, 8'd40, 8'd40, 8'd41};
    restart();
    for (int i = 0; i < 4; i++) begin
      ack_now(ins[i], ok);
      checks++; if (!ok || temp_out !== exp[i]) begin
        errors++; $display("FAIL avg_%0d got %0d want %0d", i, temp_out, exp[i]);
      end
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_sample();
    test_blank();
    test_saturate();
    test_timeout();
    test_coincident();
    test_disable();
`ifdef THERMO_AVG_EN
    test_average();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/thermo_sample_ctrl.md
# thermo_sample_ctrl

Controller that periodically sequences the temperature sensor conversion through a req/ack handshake and captures each reading. It then time-multiplexes the two 7-segment digits (tens, units) onto one shared active-low segment bus. It sits between the sensor front end and the board display, and replaces direct per-digit segment drive.

## Interface
- SAMPLE_PERIOD, 1000000: clk cycles between the end of one conversion and the next request (≥2)
- TIMEOUT, 1024: max clk cycles conv_req may stay high without conv_ack (≥1)
- SCAN_PERIOD, 50000: clk cycles each digit is lit (≥1)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  run sampling and display; low = idle and blank
- conv_req  out  1  conversion request to sensor
- conv_ack  in  1  single-cycle pulse; conv_data valid in this cycle
- conv_data  in  8  unsigned temperature, °C
- temp_out  out  8  latest captured (or averaged) temperature
- temp_valid  out  1  one-cycle pulse when temp_out updates
- sensor_err  out  1  set on timeout, cleared on next successful ack
- seg  out  7  shared segments, active-low, {g,f,e,d,c,b,a}
- an  out  2  digit anodes, active-low one-hot; an[0] units, an[1] tens

## Operation
- States: IDLE, REQ, WAIT.
- IDLE: conv_req=0. enable=1 → REQ. The first sample is taken immediately.
- REQ: conv_req=1 and the timeout counter increments.
  - conv_ack=1 → capture conv_data, clear sensor_err, go to WAIT.
  - Timeout counter reaches TIMEOUT-1 with no ack → set sensor_err, leave temp_out unchanged, go to WAIT.
  - If ack and timeout expiry occur in the same cycle, ack wins.
- WAIT: sample counter runs 0..SAMPLE_PERIOD-1, then → REQ.
- enable=0 in any state → IDLE next cycle. conv_req drops, counters clear, and an ack arriving in IDLE is ignored. temp_out and sensor_err hold their values.
- conv_ack outside REQ is ignored.
- Display value:
  - v = min(temp_out, 99); tens = v/10, units = v%10.
  - Leading tens zero is blanked (seg=7'h7F while tens is lit).
  - sensor_err=1 → both digits show "-" (7'b0111111).
  - enable=0 → an=2'b11 and seg=7'h7F.
- Scan: the free-running scan counter toggles the lit digit every SCAN_PERIOD cycles, starting with units after reset. The scan counter runs regardless of enable.
- Segment codes 0-9: 40,79,24,30,19,12,02,78,00,10 (hex).

## Timing
- Reset values: conv_req=0, temp_out=0, temp_valid=0, sensor_err=0, an=2'b11, seg=7'h7F, state=IDLE.
- enable rises at cycle N → conv_req=1 at N+1.
- conv_ack at cycle A:
  - conv_req=0 at A+1.
  - temp_out updated and temp_valid=1 at A+1.
  - Without averaging, temp_out at A+1 is the conv_data from cycle A.
- Next conv_req rises SAMPLE_PERIOD+1 cycles after the ack or timeout cycle.
- Timeout: conv_req high for exactly TIMEOUT cycles; sensor_err=1 on the cycle conv_req drops.
- an and seg are registered together and change in the same cycle. A temp_out change is visible on seg one cycle after temp_valid.
- All outputs are registered.

## Configuration
- THERMO_AVG_EN defined:
  - temp_out = (sum of last 4 captured samples) >> 2, with a 10-bit sum and truncation.
  - The first capture after reset or after leaving IDLE preloads all 4 history entries.
  - Timeouts do not enter the history.
  - Latency is unchanged: temp_out updates at A+1.
- Undefined: temp_out = raw conv_data from the ack cycle; there is no history storage.

## Structure
- Package thermo_pkg holds:
  - state enum {IDLE, REQ, WAIT};
  - SEG_BLANK = 7'h7F and SEG_DASH = 7'b0111111;
  - the 0-9 segment constants;
  - function bcd_to_seg.
- Sub-module thermo_seg_mux contains the scan counter, tens/units split, 99 saturation, blanking and the anode/segment registers. Its inputs are temp_out, sensor_err and enable.
- The top level contains the FSM, the sample and timeout counters, and the optional averager.

## Test plan
Bench parameters: SAMPLE_PERIOD=16, TIMEOUT=8, SCAN_PERIOD=4.
- Reset, then enable=1; ack with 8'd37 two cycles after conv_req rises → temp_valid pulse; temp_out=37; an alternates 10/01 every 4 cycles; seg=30 on tens, 78 on units; next conv_req rises 17 cycles after the ack.
- Single ack with 8'd5 → tens blanked (7F), units=12.
- conv_data=8'd150 → temp_out=150; display shows 99 (10/10).
- No ack → conv_req high for 8 cycles; sensor_err=1; display shows "-" on both digits; a later ack with 8'd20 clears sensor_err and shows 20.
- Ack coincident with the final timeout cycle → data captured, sensor_err stays 0. Separately, drop enable mid-REQ, then ack → ignored; temp_out unchanged; an=11.
- With THERMO_AVG_EN defined: sample sequence 40,40,40,44 (first capture preloads) → temp_out 40,40,40,41.
